// File: rtl/pipe_sequencer.sv
// ============================================================================
//  Module   : pipe_sequencer
//  Purpose  : Stall/flush controller for a four-stage F/D/E/W pipeline.
//             Produces the update codes of the F->D, D->E and E->W pipeline
//             registers and of the PC. Covers multi-cycle execute, D-vs-E RAW
//             hazards, taken branch/jump redirect, external memory stall and
//             the stop/halt/resume sequence.
//             Update code: 00 hold, 01 advance (load), 10 flush (bubble).
//  Ports    : clk, rstn (async, active-low)
//             i_d_rs / i_d_rt       decode sources {file, index[4:0]}
//             i_de_rw / i_de_rd     E-stage write enable/file and destination
//             i_de_wait_time        E-stage execute latency (0 behaves as 1)
//             i_de_stop             E-stage instruction is stop
//             i_e_branch            E-stage branch/jump taken
//             i_mem_stall           freeze whole pipeline
//             i_resume              pulse, leave HALT
//             o_fd/de/ew/pc_update  update codes
//             o_e_first             first cycle of the instruction in E
//             o_halted              controller is in HALT
//             o_stall_cnt           cycles with fd update != advance, wraps
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_sequencer #(
  parameter int WAIT_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [5:0]        i_d_rs,
  input  logic [5:0]        i_d_rt,
  input  logic [1:0]        i_de_rw,
  input  logic [4:0]        i_de_rd,
  input  logic [WAIT_W-1:0] i_de_wait_time,
  input  logic              i_de_stop,
  input  logic              i_e_branch,
  input  logic              i_mem_stall,
  input  logic              i_resume,
  output logic [1:0]        o_fd_update,
  output logic [1:0]        o_de_update,
  output logic [1:0]        o_ew_update,
  output logic [1:0]        o_pc_update,
  output logic              o_e_first,
  output logic              o_halted,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  localparam logic [1:0]        c_HOLD     = 2'b00;
  localparam logic [1:0]        c_LOAD     = 2'b01;
  localparam logic [1:0]        c_FLUSH    = 2'b10;
  localparam logic [WAIT_W-1:0] c_ECNT_ONE = WAIT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HALT = 2'b01
  } state_t;

  state_t              r_state;
  logic [WAIT_W-1:0]   r_ecnt;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic [WAIT_W-1:0]   w_wait_eff;
  logic                w_e_done;
  logic                w_hazard;
  logic [1:0]          w_fd, w_de, w_ew, w_pc;

  // A source depends on the E-stage result when E writes the same file/index.
  function automatic logic src_hit(input logic [5:0] src,
                                   input logic [1:0] rw,
                                   input logic [4:0] rd);
    return (rw != 2'b00) && (rw[1] == src[5]) && (rd == src[4:0]);
  endfunction

  always_comb begin
    w_wait_eff = (i_de_wait_time == '0) ? c_ECNT_ONE : i_de_wait_time;
    w_e_done   = (r_ecnt >= w_wait_eff);
    w_hazard   = src_hit(i_d_rs, i_de_rw, i_de_rd) |
                 src_hit(i_d_rt, i_de_rw, i_de_rd);
  end

  // Update codes; everything is held while reset is asserted.
  always_comb begin
    w_fd = c_HOLD;
    w_de = c_HOLD;
    w_ew = c_HOLD;
    w_pc = c_HOLD;
    if (rstn) begin
      if (r_state == ST_HALT) begin
        w_ew = c_FLUSH;
      end else if (i_mem_stall) begin
        w_fd = c_HOLD;
      end else if (!w_e_done) begin
        w_ew = c_FLUSH;
      end else if (i_de_stop) begin
        w_fd = c_FLUSH;
        w_de = c_FLUSH;
        w_ew = c_LOAD;
      end else if (i_e_branch) begin
        // Branch outranks a hazard: the dependent D instruction is squashed.
        w_fd = c_FLUSH;
        w_de = c_FLUSH;
        w_ew = c_LOAD;
        w_pc = c_FLUSH;
      end else if (w_hazard) begin
        w_de = c_FLUSH;
        w_ew = c_LOAD;
      end else begin
        w_fd = c_LOAD;
        w_de = c_LOAD;
        w_ew = c_LOAD;
        w_pc = c_LOAD;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_RUN;
      r_ecnt      <= c_ECNT_ONE;
      r_stall_cnt <= '0;
    end else begin
      if (w_fd != c_LOAD)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);

      case (r_state)
        ST_RUN: begin
          if (!i_mem_stall) begin
            // Any load or bubble into E starts a fresh execute count.
            if ((w_de == c_LOAD) || (w_de == c_FLUSH))
              r_ecnt <= c_ECNT_ONE;
            else if (!w_e_done && (r_ecnt != '1))
              r_ecnt <= r_ecnt + c_ECNT_ONE;
            if (w_e_done && i_de_stop)
              r_state <= ST_HALT;
          end
        end
        ST_HALT: begin
          if (i_resume)
            r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign o_fd_update = w_fd;
  assign o_de_update = w_de;
  assign o_ew_update = w_ew;
  assign o_pc_update = w_pc;
  assign o_e_first   = rstn && (r_state == ST_RUN) && (r_ecnt == c_ECNT_ONE);
  assign o_halted    = rstn && (r_state == ST_HALT);
  assign o_stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire
